// File: rtl/pos_avg_fofb.sv
// Offset-corrected boxcar averager for the FOFB position stream.
// Stage 1 subtracts the per-axis offsets with saturation. Stage 2 accumulates
// 2**AVG_LOG2 samples and closes the window. The output register presents the
// average with a one-cycle val_o strobe.
module pos_avg_fofb #(
    parameter int POS_WIDTH = 25,
    parameter int AVG_LOG2  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [POS_WIDTH-1:0] data_x_i,
    input  logic [POS_WIDTH-1:0] data_y_i,
    input  logic [POS_WIDTH-1:0] data_sum_i,
    input  logic                 val_i,
    input  logic [POS_WIDTH-1:0] offset_x_i,
    input  logic [POS_WIDTH-1:0] offset_y_i,
    output logic [POS_WIDTH-1:0] data_x_o,
    output logic [POS_WIDTH-1:0] data_y_o,
    output logic [POS_WIDTH-1:0] data_sum_o,
    output logic                 val_o,
    output logic [AVG_LOG2:0]    cnt_o
);

    localparam int AW = POS_WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};

    // One extra bit of headroom; any carry into it means the result left the range.
    function automatic logic signed [POS_WIDTH-1:0] sat_sub(
        input logic signed [POS_WIDTH-1:0] a,
        input logic signed [POS_WIDTH-1:0] b
    );
        logic signed [POS_WIDTH:0] diff;
        diff = (POS_WIDTH+1)'(a) - (POS_WIDTH+1)'(b);
        if (diff[POS_WIDTH] != diff[POS_WIDTH-1])
            sat_sub = diff[POS_WIDTH] ? POS_MIN : POS_MAX;
        else
            sat_sub = diff[POS_WIDTH-1:0];
    endfunction

    // Window mean; the arithmetic shift floors toward minus infinity.
    function automatic logic signed [POS_WIDTH-1:0] avg_of(
        input logic signed [AW-1:0]        acc,
        input logic signed [POS_WIDTH-1:0] v
    );
        logic signed [AW-1:0] total;
        total  = acc + AW'(v);
        total  = total >>> AVG_LOG2;
        avg_of = total[POS_WIDTH-1:0];
    endfunction

    logic                        vld_p1_q, vld_p1_d;
    logic signed [POS_WIDTH-1:0] x_p1_q, x_p1_d, y_p1_q, y_p1_d, sum_p1_q, sum_p1_d;
    logic signed [AW-1:0]        acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_sum_q, acc_sum_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        vld_p2_q, vld_p2_d;
    logic signed [POS_WIDTH-1:0] avg_x_q, avg_x_d, avg_y_q, avg_y_d, avg_sum_q, avg_sum_d;
    logic signed [POS_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_sum_q, out_sum_d;
    logic                        val_q, val_d;

    // Next-state logic for the correction, accumulation and output stages.
    always_comb begin
        vld_p1_d  = vld_p1_q;
        x_p1_d    = x_p1_q;
        y_p1_d    = y_p1_q;
        sum_p1_d  = sum_p1_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        acc_sum_d = acc_sum_q;
        cnt_d     = cnt_q;
        vld_p2_d  = 1'b0;
        avg_x_d   = avg_x_q;
        avg_y_d   = avg_y_q;
        avg_sum_d = avg_sum_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_sum_d = out_sum_q;

        // Stage 1: capture and offset-correct an accepted sample.
        if (clr_i) begin
            vld_p1_d = 1'b0;
        end else begin
            vld_p1_d = val_i & en_i;
            if (val_i && en_i) begin
                x_p1_d   = sat_sub($signed(data_x_i), $signed(offset_x_i));
                y_p1_d   = sat_sub($signed(data_y_i), $signed(offset_y_i));
                sum_p1_d = $signed(data_sum_i);
            end
        end

        // Stage 2: accumulate, or close the window on its last sample.
        if (clr_i) begin
            acc_x_d   = '0;
            acc_y_d   = '0;
            acc_sum_d = '0;
            cnt_d     = '0;
        end else if (vld_p1_q) begin
            if (cnt_q == CNT_LAST) begin
                avg_x_d   = avg_of(acc_x_q, x_p1_q);
                avg_y_d   = avg_of(acc_y_q, y_p1_q);
                avg_sum_d = avg_of(acc_sum_q, sum_p1_q);
                acc_x_d   = '0;
                acc_y_d   = '0;
                acc_sum_d = '0;
                cnt_d     = '0;
                vld_p2_d  = 1'b1;
            end else begin
                acc_x_d   = acc_x_q + AW'(x_p1_q);
                acc_y_d   = acc_y_q + AW'(y_p1_q);
                acc_sum_d = acc_sum_q + AW'(sum_p1_q);
                cnt_d     = cnt_q + CW'(1);
            end
        end

        // Output: present a finished average unless a clear cancels it.
        val_d = vld_p2_q & ~clr_i;
        if (vld_p2_q && !clr_i) begin
            out_x_d   = avg_x_q;
            out_y_d   = avg_y_q;
            out_sum_d = avg_sum_q;
        end
    end

    // State registers; everything returns to zero on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1_q  <= 1'b0;
            x_p1_q    <= '0;
            y_p1_q    <= '0;
            sum_p1_q  <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            acc_sum_q <= '0;
            cnt_q     <= '0;
            vld_p2_q  <= 1'b0;
            avg_x_q   <= '0;
            avg_y_q   <= '0;
            avg_sum_q <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_sum_q <= '0;
            val_q     <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            x_p1_q    <= x_p1_d;
            y_p1_q    <= y_p1_d;
            sum_p1_q  <= sum_p1_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            acc_sum_q <= acc_sum_d;
            cnt_q     <= cnt_d;
            vld_p2_q  <= vld_p2_d;
            avg_x_q   <= avg_x_d;
            avg_y_q   <= avg_y_d;
            avg_sum_q <= avg_sum_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_sum_q <= out_sum_d;
            val_q     <= val_d;
        end
    end

    assign data_x_o   = out_x_q;
    assign data_y_o   = out_y_q;
    assign data_sum_o = out_sum_q;
    assign val_o      = val_q;
    assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_pos_avg_fofb.sv
// Directed bench for pos_avg_fofb: three instances (AVG_LOG2 = 0, 2, 4) share
// one stimulus; each scenario looks at the instance it targets.
module tb_pos_avg_fofb;

    localparam int PW = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic clr = 1'b0;
    logic val = 1'b0;
    logic signed [PW-1:0] x = '0, y = '0, s = '0, off_x = '0, off_y = '0;

    logic signed [PW-1:0] x0, y0, s0, x2, y2, s2, x4, y4, s4;
    logic v0, v2, v4;
    logic [0:0] c0;
    logic [2:0] c2;
    logic [4:0] c4;

    int n_chk = 0, n_pass = 0;
    int nv0 = 0, nv2 = 0, nv4 = 0;

    always #5 clk = ~clk;

    pos_avg_fofb #(.POS_WIDTH(PW), .AVG_LOG2(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr),
        .data_x_i(x), .data_y_i(y), .data_sum_i(s), .val_i(val),
        .offset_x_i(off_x), .offset_y_i(off_y),
        .data_x_o(x0), .data_y_o(y0), .data_sum_o(s0), .val_o(v0), .cnt_o(c0));

    pos_avg_fofb #(.POS_WIDTH(PW), .AVG_LOG2(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr),
        .data_x_i(x), .data_y_i(y), .data_sum_i(s), .val_i(val),
        .offset_x_i(off_x), .offset_y_i(off_y),
        .data_x_o(x2), .data_y_o(y2), .data_sum_o(s2), .val_o(v2), .cnt_o(c2));

    pos_avg_fofb #(.POS_WIDTH(PW), .AVG_LOG2(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr),
        .data_x_i(x), .data_y_i(y), .data_sum_i(s), .val_i(val),
        .offset_x_i(off_x), .offset_y_i(off_y),
        .data_x_o(x4), .data_y_o(y4), .data_sum_o(s4), .val_o(v4), .cnt_o(c4));

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance one clock edge and sample 1 ns later, tallying val_o strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (v0) nv0++;
        if (v2) nv2++;
        if (v4) nv4++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        val = 1'b0; clr = 1'b0; en = 1'b1;
        x = '0; y = '0; s = '0; off_x = '0; off_y = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        nv0 = 0; nv2 = 0; nv4 = 0;
    endtask

    initial begin
        do_reset();
        check("rst_x2", x2, 0);
        check("rst_val2", v2, 0);
        check("rst_cnt4", c4, 0);
        check("rst_sum4", s4, 0);

        // 1: 10,20,30,40 -> 25 ; sum 4,8,12,16 -> 10
        val = 1'b1;
        x = 10; s = 4;  tick();
        x = 20; s = 8;  tick();
        x = 30; s = 12; tick();
        x = 40; s = 16; tick();
        val = 1'b0;
        check("t1_cnt_pre", c2, 3);
        tick();
        check("t1_val_e1", v2, 0);
        check("t1_cnt_wrap", c2, 0);
        tick();
        check("t1_val_e2", v2, 1);
        check("t1_x", x2, 25);
        check("t1_sum", s2, 10);
        tick();
        check("t1_val_pulse", v2, 0);
        check("t1_x_hold", x2, 25);
        check("t1_nval", nv2, 1);

        // 2: floor of -1.75
        do_reset();
        val = 1'b1;
        x = -1; tick();
        x = -2; tick();
        tick();
        tick();
        val = 1'b0;
        repeat (2) tick();
        check("t2_val", v2, 1);
        check("t2_floor", x2, -2);

        // 3: saturation and pass-through on the N=1 instance
        do_reset();
        off_x = -1; off_y = 1;
        val = 1'b1; x = 16777215; y = -16777216; s = 5;
        tick();
        val = 1'b0;
        tick();
        check("t3_val_e1", v0, 0);
        tick();
        check("t3_val_e2", v0, 1);
        check("t3_satpos", x0, 16777215);
        check("t3_satneg", y0, -16777216);
        check("t3_sum", s0, 5);
        val = 1'b1; x = 100; y = -5;
        tick();
        val = 1'b0;
        repeat (2) tick();
        check("t3_x_norm", x0, 101);
        check("t3_y_norm", y0, -6);

        // 4: clear discards samples 0..2, window over 3..6 only
        do_reset();
        val = 1'b1;
        x = 1; tick();
        x = 2; tick();
        x = 1000; clr = 1'b1; tick();
        clr = 1'b0;
        check("t4_cnt_clr", c2, 0);
        check("t4_val_clr", v2, 0);
        x = 4;  tick();
        x = 8;  tick();
        x = 12; tick();
        x = 16; tick();
        val = 1'b0;
        repeat (6) tick();
        check("t4_nval", nv2, 1);
        check("t4_x", x2, 10);

        // 5: N=16, one strobe ignored via en low
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            en = (i != 5);
            x = (i == 5) ? 10000 : i * 10;
            val = 1'b1;
            tick();
            val = 1'b0; en = 1'b1;
            repeat (49) tick();
            if (i == 5) check("t5_cnt_skip", c4, 4);
            if (i == 16) begin
                check("t5_nval16", nv4, 0);
                check("t5_cnt15", c4, 15);
            end
        end
        check("t5_nval17", nv4, 1);
        check("t5_x", x4, 92);

        // 6: async reset mid-window
        do_reset();
        off_y = 100; x = 7; y = 100; s = 50;
        val = 1'b1;
        repeat (16) tick();
        val = 1'b0;
        repeat (3) tick();
        check("t6_nval_a", nv4, 1);
        check("t6_x_a", x4, 7);
        check("t6_y_a", y4, 0);
        check("t6_sum_a", s4, 50);
        val = 1'b1;
        repeat (3) tick();
        val = 1'b0;
        repeat (2) tick();
        check("t6_cnt3", c4, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_x", x4, 0);
        check("t6_rst_sum", s4, 0);
        check("t6_rst_cnt", c4, 0);
        #2;
        rst_n = 1'b1;
        nv4 = 0;
        val = 1'b1;
        repeat (15) tick();
        val = 1'b0;
        repeat (4) tick();
        check("t6_nval15", nv4, 0);
        val = 1'b1;
        tick();
        val = 1'b0;
        repeat (3) tick();
        check("t6_nval16", nv4, 1);
        check("t6_x_b", x4, 7);
        check("t6_y_b", y4, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
